// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//
// Purpose:
//   Instruction-decode stage. Latches the fetched PC/instruction into an
//   IF/ID register, decodes the opcode into ALU command and control bits,
//   reads two operands from a 32 x 32 register file (which also takes the
//   write-back port), and registers everything into an ID/EX register for
//   the execute stage. Supports stall (hazard unit) and flush (taken branch).
//
// Configuration macro:
//   ID_WB_BYPASS_EN - when defined, a register read whose address matches an
//                     active non-R0 write-back returns wb_value in the same
//                     cycle. When undefined, the pre-write value is returned.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   if_pc          PC from fetch
//   if_instr       instruction from fetch
//   stall          hold IF/ID, insert bubble into ID/EX
//   flush          bubble both IF/ID and ID/EX (wins over stall)
//   wb_en          register-file write enable
//   wb_dest        register-file write address
//   wb_value       register-file write data
//   hz_src1        first read address of the instruction in IF/ID
//   hz_src2        second read address of the instruction in IF/ID
//   hz_uses_src2   instruction in IF/ID reads its second operand
//   id_valid       ID/EX holds a real instruction
//   id_pc          PC of the decoded instruction
//   id_val1        first operand value
//   id_val2        second operand value
//   id_imm         sign-extended instr[15:0]
//   id_dest        instr[25:21]
//   id_exe_cmd     ALU command
//   id_is_imm      second ALU operand is the immediate
//   id_wb_en       result is written back
//   id_mem_rd      memory load
//   id_mem_wr      memory store
//   id_br_type     00 none, 01 BEZ, 10 BNE, 11 JMP
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           if_pc,
  input  logic [31:0]           if_instr,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]     wb_value,
  output logic [REG_ADDR_W-1:0] hz_src1,
  output logic [REG_ADDR_W-1:0] hz_src2,
  output logic                  hz_uses_src2,
  output logic                  id_valid,
  output logic [31:0]           id_pc,
  output logic [DATA_W-1:0]     id_val1,
  output logic [DATA_W-1:0]     id_val2,
  output logic [31:0]           id_imm,
  output logic [REG_ADDR_W-1:0] id_dest,
  output logic [3:0]            id_exe_cmd,
  output logic                  id_is_imm,
  output logic                  id_wb_en,
  output logic                  id_mem_rd,
  output logic                  id_mem_wr,
  output logic [1:0]            id_br_type
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h03;
  localparam logic [5:0] OP_AND  = 6'h05;
  localparam logic [5:0] OP_OR   = 6'h06;
  localparam logic [5:0] OP_NOR  = 6'h07;
  localparam logic [5:0] OP_XOR  = 6'h08;
  localparam logic [5:0] OP_SLA  = 6'h09;
  localparam logic [5:0] OP_SLL  = 6'h0A;
  localparam logic [5:0] OP_SRA  = 6'h0B;
  localparam logic [5:0] OP_SRL  = 6'h0C;
  localparam logic [5:0] OP_ADDI = 6'h20;
  localparam logic [5:0] OP_SUBI = 6'h21;
  localparam logic [5:0] OP_LD   = 6'h24;
  localparam logic [5:0] OP_ST   = 6'h25;
  localparam logic [5:0] OP_BEZ  = 6'h28;
  localparam logic [5:0] OP_BNE  = 6'h29;
  localparam logic [5:0] OP_JMP  = 6'h2A;

  // -------------------------------------------------------------------------
  // IF/ID register
  // -------------------------------------------------------------------------
  logic [31:0] ifid_pc_reg;
  logic [31:0] ifid_instr_reg;
  logic        ifid_valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_pc_reg    <= '0;
      ifid_instr_reg <= '0;
      ifid_valid_reg <= 1'b0;
    end else if (flush) begin
      // A cleared instruction decodes as NOP, so hz_* go quiet as well.
      ifid_pc_reg    <= '0;
      ifid_instr_reg <= '0;
      ifid_valid_reg <= 1'b0;
    end else if (!stall) begin
      ifid_pc_reg    <= if_pc;
      ifid_instr_reg <= if_instr;
      ifid_valid_reg <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Field extraction and decode (purely from IF/ID contents)
  // -------------------------------------------------------------------------
  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] f_dest;
  logic [REG_ADDR_W-1:0] f_src1;
  logic [REG_ADDR_W-1:0] f_src2;
  logic [31:0]           imm_ext;

  assign opcode  = ifid_instr_reg[31:26];
  assign f_dest  = ifid_instr_reg[25:21];
  assign f_src1  = ifid_instr_reg[20:16];
  assign f_src2  = ifid_instr_reg[15:11];
  assign imm_ext = {{16{ifid_instr_reg[15]}}, ifid_instr_reg[15:0]};

  logic [3:0] dec_exe_cmd;
  logic       dec_is_imm;
  logic       dec_wb_en;
  logic       dec_mem_rd;
  logic       dec_mem_wr;
  logic [1:0] dec_br_type;
  logic       dec_uses_src2;
  logic       dec_src2_is_dest;

  always_comb begin
    dec_exe_cmd      = 4'b0000;
    dec_is_imm       = 1'b0;
    dec_wb_en        = 1'b0;
    dec_mem_rd       = 1'b0;
    dec_mem_wr       = 1'b0;
    dec_br_type      = 2'b00;
    dec_uses_src2    = 1'b0;
    dec_src2_is_dest = 1'b0;
    unique case (opcode)
      OP_ADD:  begin dec_exe_cmd = 4'b0000; dec_wb_en = 1'b1; dec_uses_src2 = 1'b1; end
      OP_SUB:  begin dec_exe_cmd = 4'b0010; dec_wb_en = 1'b1; dec_uses_src2 = 1'b1; end
      OP_AND:  begin dec_exe_cmd = 4'b0100; dec_wb_en = 1'b1; dec_uses_src2 = 1'b1; end
      OP_OR:   begin dec_exe_cmd = 4'b0101; dec_wb_en = 1'b1; dec_uses_src2 = 1'b1; end
      OP_NOR:  begin dec_exe_cmd = 4'b0110; dec_wb_en = 1'b1; dec_uses_src2 = 1'b1; end
      OP_XOR:  begin dec_exe_cmd = 4'b0111; dec_wb_en = 1'b1; dec_uses_src2 = 1'b1; end
      OP_SLA,
      OP_SLL:  begin dec_exe_cmd = 4'b1000; dec_wb_en = 1'b1; dec_uses_src2 = 1'b1; end
      OP_SRA:  begin dec_exe_cmd = 4'b1001; dec_wb_en = 1'b1; dec_uses_src2 = 1'b1; end
      OP_SRL:  begin dec_exe_cmd = 4'b1010; dec_wb_en = 1'b1; dec_uses_src2 = 1'b1; end
      OP_ADDI: begin dec_exe_cmd = 4'b0000; dec_is_imm = 1'b1; dec_wb_en = 1'b1; end
      OP_SUBI: begin dec_exe_cmd = 4'b0010; dec_is_imm = 1'b1; dec_wb_en = 1'b1; end
      OP_LD:   begin
        dec_exe_cmd = 4'b0000; dec_is_imm = 1'b1; dec_mem_rd = 1'b1; dec_wb_en = 1'b1;
      end
      // ST reads the store data through the dest field.
      OP_ST:   begin
        dec_exe_cmd = 4'b0000; dec_is_imm = 1'b1; dec_mem_wr = 1'b1;
        dec_uses_src2 = 1'b1; dec_src2_is_dest = 1'b1;
      end
      OP_BEZ:  begin dec_br_type = 2'b01; dec_is_imm = 1'b1; end
      // BNE compares src1 against the register named by dest.
      OP_BNE:  begin
        dec_br_type = 2'b10; dec_is_imm = 1'b1;
        dec_uses_src2 = 1'b1; dec_src2_is_dest = 1'b1;
      end
      OP_JMP:  begin dec_br_type = 2'b11; dec_is_imm = 1'b1; end
      default: ; // NOP and undefined opcodes: all controls stay 0
    endcase
  end

  assign hz_src1      = f_src1;
  assign hz_src2      = dec_src2_is_dest ? f_dest : f_src2;
  assign hz_uses_src2 = dec_uses_src2;

  // -------------------------------------------------------------------------
  // Register file: R1..R31 are storage, R0 is hard-wired to zero and has no
  // storage row at all.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] rf_reg [1:NUM_REGS-1];

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_rf_row
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rf_reg[gi] <= '0;
        end else if (wb_en && (wb_dest == REG_ADDR_W'(gi))) begin
          rf_reg[gi] <= wb_value;
        end
      end
    end
  endgenerate

  logic [REG_ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0]     rd_val  [2];

  assign rd_addr[0] = hz_src1;
  assign rd_addr[1] = hz_src2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      always_comb begin
        rd_val[gi] = '0;
        if (rd_addr[gi] != '0) begin
          rd_val[gi] = rf_reg[rd_addr[gi]];
        end
`ifdef ID_WB_BYPASS_EN
        // Write-through: the value being written this cycle is visible now.
        if (wb_en && (wb_dest != '0) && (wb_dest == rd_addr[gi])) begin
          rd_val[gi] = wb_value;
        end
`endif
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // ID/EX register. A bubble zeroes every field, including data fields, so
  // downstream never sees stale operands on an invalid slot.
  // -------------------------------------------------------------------------
  logic                  idex_valid_reg;
  logic [31:0]           idex_pc_reg;
  logic [DATA_W-1:0]     idex_val1_reg;
  logic [DATA_W-1:0]     idex_val2_reg;
  logic [31:0]           idex_imm_reg;
  logic [REG_ADDR_W-1:0] idex_dest_reg;
  logic [3:0]            idex_exe_cmd_reg;
  logic                  idex_is_imm_reg;
  logic                  idex_wb_en_reg;
  logic                  idex_mem_rd_reg;
  logic                  idex_mem_wr_reg;
  logic [1:0]            idex_br_type_reg;

  logic bubble;
  // An empty IF/ID slot propagates as a bubble as well.
  assign bubble = flush || stall || !ifid_valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || bubble) begin
      idex_valid_reg   <= 1'b0;
      idex_pc_reg      <= '0;
      idex_val1_reg    <= '0;
      idex_val2_reg    <= '0;
      idex_imm_reg     <= '0;
      idex_dest_reg    <= '0;
      idex_exe_cmd_reg <= '0;
      idex_is_imm_reg  <= 1'b0;
      idex_wb_en_reg   <= 1'b0;
      idex_mem_rd_reg  <= 1'b0;
      idex_mem_wr_reg  <= 1'b0;
      idex_br_type_reg <= '0;
    end else begin
      idex_valid_reg   <= ifid_valid_reg;
      idex_pc_reg      <= ifid_pc_reg;
      idex_val1_reg    <= rd_val[0];
      idex_val2_reg    <= rd_val[1];
      idex_imm_reg     <= imm_ext;
      idex_dest_reg    <= f_dest;
      idex_exe_cmd_reg <= dec_exe_cmd;
      idex_is_imm_reg  <= dec_is_imm;
      idex_wb_en_reg   <= dec_wb_en;
      idex_mem_rd_reg  <= dec_mem_rd;
      idex_mem_wr_reg  <= dec_mem_wr;
      idex_br_type_reg <= dec_br_type;
    end
  end

  assign id_valid   = idex_valid_reg;
  assign id_pc      = idex_pc_reg;
  assign id_val1    = idex_val1_reg;
  assign id_val2    = idex_val2_reg;
  assign id_imm     = idex_imm_reg;
  assign id_dest    = idex_dest_reg;
  assign id_exe_cmd = idex_exe_cmd_reg;
  assign id_is_imm  = idex_is_imm_reg;
  assign id_wb_en   = idex_wb_en_reg;
  assign id_mem_rd  = idex_mem_rd_reg;
  assign id_mem_wr  = idex_mem_wr_reg;
  assign id_br_type = idex_br_type_reg;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_value;
  logic [4:0]  hz_src1;
  logic [4:0]  hz_src2;
  logic        hz_uses_src2;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_val1;
  logic [31:0] id_val2;
  logic [31:0] id_imm;
  logic [4:0]  id_dest;
  logic [3:0]  id_exe_cmd;
  logic        id_is_imm;
  logic        id_wb_en;
  logic        id_mem_rd;
  logic        id_mem_wr;
  logic [1:0]  id_br_type;

  int total = 0;
  int bad   = 0;

  id_stage dut (
    .clk         (clk),
    .rst         (rst),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .stall       (stall),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_dest     (wb_dest),
    .wb_value    (wb_value),
    .hz_src1     (hz_src1),
    .hz_src2     (hz_src2),
    .hz_uses_src2(hz_uses_src2),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_val1     (id_val1),
    .id_val2     (id_val2),
    .id_imm      (id_imm),
    .id_dest     (id_dest),
    .id_exe_cmd  (id_exe_cmd),
    .id_is_imm   (id_is_imm),
    .id_wb_en    (id_wb_en),
    .id_mem_rd   (id_mem_rd),
    .id_mem_wr   (id_mem_wr),
    .id_br_type  (id_br_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  // One clock edge; inputs are changed and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] v);
    wb_en = 1'b1; wb_dest = a; wb_value = v;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    if_pc = pc; if_instr = instr;
  endtask

  logic [31:0] exp_r2;

  initial begin
    rst = 1'b0; if_pc = '0; if_instr = '0; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_dest = '0; wb_value = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, id_valid}, 32'd0);
    check("rst_pc", id_pc, 32'd0);
    check("rst_hz_src1", {27'b0, hz_src1}, 32'd0);
    rst = 1'b1;

    // ---- preload registers ----
    wb_write(5'd1, 32'd7);
    wb_write(5'd3, 32'h1234);
    wb_write(5'd2, 32'h11);
    wb_write(5'd5, 32'h77);

    // ---- ADDI R1 <- R1 + 5 ----
    fetch(32'h100, 32'h80210005);
    tick();
    check("addi_hz_src1", {27'b0, hz_src1}, 32'd1);
    check("addi_hz_use2", {31'b0, hz_uses_src2}, 32'd0);
    fetch(32'h104, 32'h0);
    tick();
    check("addi_valid", {31'b0, id_valid}, 32'd1);
    check("addi_pc", id_pc, 32'h100);
    check("addi_val1", id_val1, 32'd7);
    check("addi_imm", id_imm, 32'd5);
    check("addi_is_imm", {31'b0, id_is_imm}, 32'd1);
    check("addi_wb_en", {31'b0, id_wb_en}, 32'd1);
    check("addi_dest", {27'b0, id_dest}, 32'd1);

    // ---- ST R3 -> [R1 + 0xFFF1] ----
    fetch(32'h108, 32'h9461FFF1);
    tick();
    check("st_hz_src2", {27'b0, hz_src2}, 32'd3);
    check("st_hz_use2", {31'b0, hz_uses_src2}, 32'd1);
    fetch(32'h10C, 32'h0);
    tick();
    check("st_imm", id_imm, 32'hFFFFFFF1);
    check("st_val2", id_val2, 32'h1234);
    check("st_mem_wr", {31'b0, id_mem_wr}, 32'd1);
    check("st_wb_en", {31'b0, id_wb_en}, 32'd0);

    // ---- BNE R1, R3 ----
    fetch(32'h110, 32'hA4610010);
    tick();
    fetch(32'h114, 32'h0);
    tick();
    check("bne_br_type", {30'b0, id_br_type}, 32'd2);
    check("bne_val2", id_val2, 32'h1234);
    check("bne_imm", id_imm, 32'h10);

    // ---- SUB held by a 2-cycle stall, followed by ADD ----
    fetch(32'h200, 32'h0CA11800);
    tick();
    fetch(32'h204, 32'h04C10800);
    stall = 1'b1;
    tick();
    check("stall1_valid", {31'b0, id_valid}, 32'd0);
    check("stall1_hz_src1", {27'b0, hz_src1}, 32'd1);
    check("stall1_hz_src2", {27'b0, hz_src2}, 32'd3);
    tick();
    check("stall2_valid", {31'b0, id_valid}, 32'd0);
    check("stall2_hz_src2", {27'b0, hz_src2}, 32'd3);
    stall = 1'b0;
    tick();
    check("sub_valid", {31'b0, id_valid}, 32'd1);
    check("sub_pc", id_pc, 32'h200);
    check("sub_cmd", {28'b0, id_exe_cmd}, 32'd2);
    check("sub_val1", id_val1, 32'd7);
    check("sub_val2", id_val2, 32'h1234);
    fetch(32'h208, 32'h0);
    tick();
    check("add_after_pc", id_pc, 32'h204);
    check("add_after_cmd", {28'b0, id_exe_cmd}, 32'd0);
    check("add_after_val2", id_val2, 32'd7);

    // ---- flush and stall together ----
    fetch(32'h300, 32'h20E11800);
    tick();
    fetch(32'h304, 32'h19011800);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_valid", {31'b0, id_valid}, 32'd0);
    check("flush_hz_src1", {27'b0, hz_src1}, 32'd0);
    check("flush_hz_use2", {31'b0, hz_uses_src2}, 32'd0);
    flush = 1'b0; stall = 1'b0;
    tick();
    check("flush_next_valid", {31'b0, id_valid}, 32'd0);
    fetch(32'h308, 32'h0);
    tick();
    check("or_valid", {31'b0, id_valid}, 32'd1);
    check("or_pc", id_pc, 32'h304);
    check("or_cmd", {28'b0, id_exe_cmd}, 32'd5);
    check("or_dest", {27'b0, id_dest}, 32'd8);

    // ---- same-cycle write/read of R2 ----
    fetch(32'h400, 32'h05220000);
    tick();
    fetch(32'h404, 32'h0);
    wb_en = 1'b1; wb_dest = 5'd2; wb_value = 32'h55;
    tick();
    wb_en = 1'b0;
`ifdef ID_WB_BYPASS_EN
    exp_r2 = 32'h55;
`else
    exp_r2 = 32'h11;
`endif
    check("same_cycle_val1", id_val1, exp_r2);
    check("same_cycle_r0", id_val2, 32'd0);

    // ---- write to R0 is ignored ----
    wb_write(5'd0, 32'hDEAD);
    fetch(32'h500, 32'h05401000);
    tick();
    fetch(32'h504, 32'h0);
    tick();
    check("r0_read", id_val1, 32'd0);
    check("r2_after_wb", id_val2, 32'h55);

    // ---- asynchronous reset mid-run with ADD in IF/ID ----
    fetch(32'h600, 32'h04C10800);
    tick();
    tick();
    check("pre_rst_valid", {31'b0, id_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, id_valid}, 32'd0);
    check("async_rst_pc", id_pc, 32'd0);
    check("async_rst_val1", id_val1, 32'd0);
    check("async_rst_wb_en", {31'b0, id_wb_en}, 32'd0);
    check("async_rst_hz_src1", {27'b0, hz_src1}, 32'd0);
    #1 rst = 1'b1;
    fetch(32'h700, 32'h04250000);
    tick();
    fetch(32'h704, 32'h0);
    tick();
    check("post_rst_valid", {31'b0, id_valid}, 32'd1);
    check("post_rst_r5", id_val1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage directly downstream of the fetch stage. It latches the fetched PC/instruction into an IF/ID register, decodes opcode fields, and reads two operands from a 32×32 register file that also accepts the write-back port. It registers the result into an ID/EX register feeding the execute stage. It supports stall (hazard unit) and flush (taken branch) controls.

## Interface
- DATA_W, 32, datapath / register width
- REG_ADDR_W, 5, register address width (32 registers)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- if_pc  in  32  PC from fetch stage
- if_instr  in  32  instruction from fetch stage
- stall  in  1  hold IF/ID, inject bubble into ID/EX
- flush  in  1  bubble both IF/ID and ID/EX
- wb_en  in  1  register-file write enable
- wb_dest  in  5  write address
- wb_value  in  32  write data
- hz_src1, hz_src2  out  5  combinational read addresses of the instruction in IF/ID (for the hazard unit)
- hz_uses_src2  out  1  combinational; second operand is read from the register file
- id_valid  out  1  ID/EX holds a real instruction
- id_pc  out  32  PC of the decoded instruction
- id_val1, id_val2  out  32  operand values
- id_imm  out  32  sign-extended instr[15:0]
- id_dest  out  5  instr[25:21]
- id_exe_cmd  out  4  ALU command
- id_is_imm, id_wb_en, id_mem_rd, id_mem_wr  out  1  control bits
- id_br_type  out  2  00 none, 01 BEZ, 10 BNE, 11 JMP

## Operation
- Fields:
  - opcode = [31:26]
  - dest = [25:21]
  - src1 = [20:16]
  - src2 = [15:11]
  - imm = [15:0]
- Second read address:
  - dest field for ST and BNE.
  - src2 field otherwise.
- Opcode decode (exe_cmd, controls):
  - 0x00 NOP: all controls 0.
  - 0x01 ADD: exe_cmd 0000, wb.
  - 0x03 SUB: exe_cmd 0010, wb.
  - 0x05 AND: exe_cmd 0100, wb.
  - 0x06 OR: exe_cmd 0101, wb.
  - 0x07 NOR: exe_cmd 0110, wb.
  - 0x08 XOR: exe_cmd 0111, wb.
  - 0x09 SLA and 0x0A SLL: exe_cmd 1000, wb.
  - 0x0B SRA: exe_cmd 1001, wb.
  - 0x0C SRL: exe_cmd 1010, wb.
  - 0x20 ADDI: exe_cmd 0000, imm, wb.
  - 0x21 SUBI: exe_cmd 0010, imm, wb.
  - 0x24 LD: exe_cmd 0000, imm, mem_rd, wb.
  - 0x25 ST: exe_cmd 0000, imm, mem_wr.
  - 0x28 BEZ: br 01, imm.
  - 0x29 BNE: br 10, imm.
  - 0x2A JMP: br 11, imm.
  - Any other opcode decodes as NOP.
- hz_uses_src2 is 1 for R-type ALU ops, ST, and BNE.
- Register file:
  - Two combinational reads, one synchronous write on the rising edge when wb_en=1.
  - Writes to R0 are ignored.
  - R0 always reads 0.
- Bubble: id_valid=0 and all control bits 0. id_pc, id_val*, id_imm, and id_dest are 0.
- IF/ID priority per edge:
  - flush → instr ← 0, valid ← 0.
  - Else stall → hold.
  - Else capture if_pc/if_instr, valid ← 1.
- ID/EX priority per edge:
  - flush or stall → bubble.
  - Else capture the decode of IF/ID. The IF/ID valid bit passes through.

## Timing
- Reset (rst=0, asynchronous): IF/ID, ID/EX, and all 32 registers clear to 0. All outputs are 0 during reset.
- Latency: an instruction present on if_instr before edge N is on the id_* outputs after edge N+1 (2 edges).
- Stall is level-sensitive. An instruction held k cycles produces k bubbles, then issues once.
- flush and stall asserted together: flush wins.
- Write-back and read of the same nonzero register in the same cycle: behaviour is fixed by the configuration below.
- hz_* outputs change only with IF/ID contents (no combinational path from stall/flush).

## Configuration
- ID_WB_BYPASS_EN:
  - Defined: a read whose address equals wb_dest while wb_en=1 and wb_dest≠0 returns wb_value in that same cycle (write-through).
  - Undefined: the read returns the pre-write register value. The hazard unit must cover the extra cycle.

## Test plan
- Reset: rst=0 mid-run with IF/ID holding ADD → all id_* = 0 immediately. Register read of R5 after release = 0.
- ADDI flow: write R1=7 via wb port, then fetch 0x80210005 (ADDI dest R1, src1 R1, imm 5) → two edges later: id_valid=1, id_val1=7, id_imm=5, id_is_imm=1, id_wb_en=1, id_dest=1.
- Sign extension / ST: fetch ST with imm=0xFFF1 and dest R3=0x1234 → id_imm=0xFFFFFFF1, id_val2=0x1234, id_mem_wr=1, id_wb_en=0.
- Stall 2 cycles while holding SUB → two bubbles (id_valid=0), then SUB issued exactly once. hz_src1/hz_src2 are stable throughout.
- Flush with stall simultaneously → IF/ID and ID/EX both bubble. The next fetched instruction issues normally.
- Same-cycle write/read of R2=0x55 → id_val = 0x55 with ID_WB_BYPASS_EN, old value without it. A write to R0 is ignored (reads 0).
